// File: rtl/rtc_ascii_framer.sv
// rtc_ascii_framer: turns one DS1302 BCD snapshot into "20YY-MM-DD HH:MM:SS"
// (optionally followed by CR LF) and streams it over a valid/ready byte port.
module rtc_ascii_framer #(
  parameter logic [7:0] CENTURY   = 8'h20,
  parameter bit         SEND_CRLF = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       dataValid,
  input  logic [7:0] secData,
  input  logic [7:0] minData,
  input  logic [7:0] hrsData,
  input  logic [7:0] dateData,
  input  logic [7:0] monData,
  input  logic [7:0] yrData,
  input  logic       txReady,
  output logic       txValid,
  output logic [7:0] txData,
  output logic       busy,
  output logic       frameDone,
  output logic       overrun
);

  localparam logic [4:0] LAST_IDX = SEND_CRLF ? 5'd20 : 5'd18;

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  // Masked snapshot; hrs is always held as {tens[1:0], units[3:0]}.
  typedef struct packed {
    logic [7:0] yr;
    logic [4:0] mon;
    logic [5:0] date;
    logic [5:0] hrs;
    logic [6:0] mins;
    logic [6:0] secs;
  } snap_t;

  state_t     state, state_n;
  logic [4:0] idx, idx_n;
  snap_t      snap_p0, snap_n, snap_in;
  logic       txValid_n, busy_n, frameDone_n, overrun_n;
  logic [7:0] txData_n;

  // Bits of the raw registers that carry no time digits (CH, AM/PM-select, spares).
  logic unused_bits;
  assign unused_bits = ^{secData[7], minData[7], dateData[7:6], monData[7:5], hrsData[6]};

  // One BCD nibble to ASCII; out-of-range nibbles become '?'.
  function automatic logic [7:0] digit(input logic [3:0] n);
    logic [7:0] c;
    c = (n > 4'd9) ? 8'h3F : (8'h30 + {4'h0, n});
    return c;
  endfunction

  // Byte at position i of the frame built from snapshot s.
  function automatic logic [7:0] frame_byte(input logic [4:0] i, input snap_t s);
    logic [7:0] b;
    b = 8'h00;
    case (i)
      5'd0:  b = digit(CENTURY[7:4]);
      5'd1:  b = digit(CENTURY[3:0]);
      5'd2:  b = digit(s.yr[7:4]);
      5'd3:  b = digit(s.yr[3:0]);
      5'd4:  b = 8'h2D;
      5'd5:  b = digit({3'b000, s.mon[4]});
      5'd6:  b = digit(s.mon[3:0]);
      5'd7:  b = 8'h2D;
      5'd8:  b = digit({2'b00, s.date[5:4]});
      5'd9:  b = digit(s.date[3:0]);
      5'd10: b = 8'h20;
      5'd11: b = digit({2'b00, s.hrs[5:4]});
      5'd12: b = digit(s.hrs[3:0]);
      5'd13: b = 8'h3A;
      5'd14: b = digit({1'b0, s.mins[6:4]});
      5'd15: b = digit(s.mins[3:0]);
      5'd16: b = 8'h3A;
      5'd17: b = digit({1'b0, s.secs[6:4]});
      5'd18: b = digit(s.secs[3:0]);
      5'd19: b = 8'h0D;
      5'd20: b = 8'h0A;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Mask the raw registers; 12 h mode keeps only bit4 as the hours tens digit.
  always_comb begin
    snap_in      = '0;
    snap_in.yr   = yrData;
    snap_in.mon  = monData[4:0];
    snap_in.date = dateData[5:0];
    snap_in.hrs  = hrsData[7] ? {1'b0, hrsData[4], hrsData[3:0]} : hrsData[5:0];
    snap_in.mins = minData[6:0];
    snap_in.secs = secData[6:0];
  end

  // Next-state logic; every output is computed here one cycle ahead and registered.
  always_comb begin
    state_n     = state;
    idx_n       = idx;
    snap_n      = snap_p0;
    txValid_n   = txValid;
    txData_n    = txData;
    busy_n      = busy;
    frameDone_n = 1'b0;
    overrun_n   = overrun;
    case (state)
      IDLE: begin
        txValid_n = 1'b0;
        busy_n    = 1'b0;
        if (dataValid && en && !busy) begin
          snap_n    = snap_in;
          idx_n     = 5'd0;
          overrun_n = 1'b0;
          txValid_n = 1'b1;
          txData_n  = frame_byte(5'd0, snap_in);
          busy_n    = 1'b1;
          state_n   = SEND;
        end
      end
      SEND: begin
        txValid_n = 1'b1;
        busy_n    = 1'b1;
        if (dataValid && en) overrun_n = 1'b1;
        if (txValid && txReady) begin
          if (idx == LAST_IDX) begin
            txValid_n   = 1'b0;
            frameDone_n = 1'b1;
            state_n     = DONE;
          end else begin
            idx_n    = idx + 5'd1;
            txData_n = frame_byte(idx + 5'd1, snap_p0);
          end
        end
      end
      DONE: begin
        if (dataValid && en) overrun_n = 1'b1;
        txValid_n = 1'b0;
        busy_n    = 1'b0;
        state_n   = IDLE;
      end
      default: begin
        txValid_n = 1'b0;
        busy_n    = 1'b0;
        state_n   = IDLE;
      end
    endcase
  end

  // State, snapshot and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= 5'd0;
      snap_p0   <= '0;
      txValid   <= 1'b0;
      txData    <= 8'h00;
      busy      <= 1'b0;
      frameDone <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      snap_p0   <= snap_n;
      txValid   <= txValid_n;
      txData    <= txData_n;
      busy      <= busy_n;
      frameDone <= frameDone_n;
      overrun   <= overrun_n;
    end
  end

endmodule
